// File: rtl/serial_acc_core.sv
// Serial accumulator processor: deserialises {start, op[1:0], operand} frames on data,
// executes LOAD/ADD/SUB/XOR against the accumulator and shifts the result out LSB-first.
module serial_acc_core #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  output logic write,
  output logic result,
  output logic carry,
  output logic busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_OP   = 3'd1,
    RX_DATA = 3'd2,
    EXEC    = 3'd3,
    TX      = 3'd4
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opd_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sh_q;
  logic             carry_q;
  logic [WIDTH:0]   exec_d;

  // Result in the low WIDTH bits, carry/borrow in bit WIDTH.
  function automatic logic [WIDTH:0] alu(input logic [1:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (op)
      2'b00:   r = {1'b0, b};
      2'b01:   r = {1'b0, a} + {1'b0, b};
      2'b10:   r = {1'b0, a} - {1'b0, b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  assign exec_d = alu(op_q, acc_q, opd_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opd_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!data) state_q <= RX_OP;
        end
        // Opcode then operand arrive LSB-first, shifted in from the top.
        RX_OP: begin
          op_q <= {data, op_q[1]};
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            state_q <= RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          opd_q <= {data, opd_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            cnt_q   <= '0;
            state_q <= EXEC;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // Execute: accumulator, flag and output shifter all load together.
        EXEC: begin
          acc_q   <= exec_d[WIDTH-1:0];
          sh_q    <= exec_d[WIDTH-1:0];
          carry_q <= exec_d[WIDTH];
          cnt_q   <= '0;
          state_q <= TX;
        end
        TX: begin
          sh_q <= {1'b0, sh_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign write  = (state_q == TX);
  assign busy   = (state_q != IDLE);
  assign result = sh_q[0];
  assign carry  = carry_q;

endmodule

// File: tb/tb_serial_acc_core.sv
// Randomised scoreboard bench for serial_acc_core at WIDTH 8 and WIDTH 4.
module tb_serial_acc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic data8, write8, result8, carry8, busy8;
  logic data4, write4, result4, carry4, busy4;

  serial_acc_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .data(data8),
    .write(write8), .result(result8), .carry(carry8), .busy(busy8)
  );

  serial_acc_core #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .data(data4),
    .write(write4), .result(result4), .carry(carry4), .busy(busy4)
  );

  typedef struct {
    int val;
    int cy;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   acc8_m = 0, cy8_m = 0;
  int   acc4_m = 0, cy4_m = 0;
  int   checks = 0;
  int   passes = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Reference behaviour: plain unsigned arithmetic on integers.
  function automatic int step(input int w, input int op, input int opd,
                              input int acc, output int cy);
    int mask;
    int s;
    mask = (1 << w) - 1;
    case (op)
      0: begin s = opd;               cy = 0; end
      1: begin s = acc + opd;         cy = (s > mask) ? 1 : 0; end
      2: begin s = acc - opd;         cy = (acc < opd) ? 1 : 0; end
      default: begin s = acc ^ opd;   cy = 0; end
    endcase
    return s & mask;
  endfunction

  function automatic void drive(input int w, input logic b);
    if (w == 8) data8 = b;
    else        data4 = b;
  endfunction

  function automatic int busy_of(input int w);
    return (w == 8) ? int'(busy8) : int'(busy4);
  endfunction

  function automatic int write_of(input int w);
    return (w == 8) ? int'(write8) : int'(write4);
  endfunction

  // Sends one frame; returns #1 after the TX->IDLE edge so a following call is back-to-back.
  task automatic send(input int w, input int op, input int opd, input bit toggle);
    int  cy;
    logic t;
    if (w == 8) begin
      acc8_m = step(8, op, opd, acc8_m, cy);
      cy8_m = cy;
      q8.push_back('{acc8_m, cy8_m});
    end else begin
      acc4_m = step(4, op, opd, acc4_m, cy);
      cy4_m = cy;
      q4.push_back('{acc4_m, cy4_m});
    end
    drive(w, 1'b0);
    @(posedge clk); #1;
    check($sformatf("w%0d busy after start", w), busy_of(w), 1);
    for (int i = 0; i < 2; i++) begin
      drive(w, 1'(op >> i));
      @(posedge clk); #1;
    end
    for (int i = 0; i < w; i++) begin
      drive(w, 1'(opd >> i));
      @(posedge clk); #1;
    end
    t = 1'b0;
    drive(w, 1'b1);
    for (int i = 0; i <= w; i++) begin
      if (toggle) begin
        drive(w, t);
        t = ~t;
      end
      @(posedge clk); #1;
      if (i == 0)     check($sformatf("w%0d write after exec", w), write_of(w), 1);
      if (i == w - 1) check($sformatf("w%0d busy before last edge", w), busy_of(w), 1);
    end
    drive(w, 1'b1);
    check($sformatf("w%0d busy after frame", w), busy_of(w), 0);
    check($sformatf("w%0d write after frame", w), write_of(w), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitors: collect each write burst and compare against the scoreboard head.
  int   n8 = 0, got8 = 0, n4 = 0, got4 = 0;
  exp_t e8, e4;

  always @(negedge clk) begin
    if (!rst) begin
      n8 = 0; got8 = 0;
    end else if (write8) begin
      got8 = got8 | (int'(result8) << n8);
      n8++;
      if (n8 == 8) begin
        if (q8.size() == 0) check("w8 unexpected frame", got8, -1);
        else begin
          e8 = q8.pop_front();
          check("w8 result", got8, e8.val);
          check("w8 carry", int'(carry8), e8.cy);
        end
        n8 = 0; got8 = 0;
      end
    end else if (n8 != 0) begin
      check("w8 burst length", n8, 8);
      n8 = 0; got8 = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n4 = 0; got4 = 0;
    end else if (write4) begin
      got4 = got4 | (int'(result4) << n4);
      n4++;
      if (n4 == 4) begin
        if (q4.size() == 0) check("w4 unexpected frame", got4, -1);
        else begin
          e4 = q4.pop_front();
          check("w4 result", got4, e4.val);
          check("w4 carry", int'(carry4), e4.cy);
        end
        n4 = 0; got4 = 0;
      end
    end else if (n4 != 0) begin
      check("w4 burst length", n4, 4);
      n4 = 0; got4 = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    data8 = 1'b1;
    data4 = 1'b1;
    #12 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      check("idle write", int'(write8), 0);
      check("idle result", int'(result8), 0);
      check("idle busy", int'(busy8), 0);
      check("idle carry", int'(carry8), 0);
      @(posedge clk); #1;
    end

    send(8, 0, 8'hA5, 1'b0);
    send(8, 1, 8'h70, 1'b0);
    send(8, 2, 8'h20, 1'b0);
    send(8, 3, 8'hFF, 1'b0);
    idle_cycles(3);
    send(8, 0, 8'h3C, 1'b1);
    idle_cycles(2);

    // Abort: reset pulse while operand bit 4 of an ADD 0x01 is on the line.
    send(8, 0, 8'h80, 1'b0);
    data8 = 1'b0;
    @(posedge clk); #1;
    data8 = 1'b1; @(posedge clk); #1;
    data8 = 1'b0; @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      data8 = 1'(8'h01 >> i);
      @(posedge clk); #1;
    end
    data8 = 1'b0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    acc8_m = 0; cy8_m = 0;
    acc4_m = 0; cy4_m = 0;
    data8 = 1'b1;
    check("busy after abort", int'(busy8), 0);
    check("carry after abort", int'(carry8), 0);
    idle_cycles(3);
    send(8, 1, 8'h03, 1'b0);

    for (int k = 0; k < 40; k++) begin
      send(8, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    send(4, 0, 4'hF, 1'b0);
    send(4, 1, 4'h1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      send(4, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    idle_cycles(4);
    check("w8 scoreboard drained", q8.size(), 0);
    check("w4 scoreboard drained", q4.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_acc_core.md
# serial_acc_core

Parametrised serial accumulator processor. Receives framed instructions as a 1-bit stream on `data`, deserialises a 2-bit opcode and a WIDTH-bit operand, and executes it against an internal WIDTH-bit accumulator. It then shifts the new accumulator value out LSB-first on `result`, with `write` qualifying each bit. It is the generalised successor to the team's single-bit serial processor top, adding width, an ALU opcode set, a carry/borrow flag and a busy indication.

## Interface
- `WIDTH`, default 8: accumulator/operand width in bits; legal range 2..32.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `data` input 1: serial instruction line; idles high.
- `write` output 1: high while `result` carries a valid accumulator bit.
- `result` output 1: serial accumulator output, LSB first.
- `carry` output 1: flag from the last executed instruction; registered.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Frame on `data`, one bit per clock:
  - start bit `0`;
  - `op[0]`, then `op[1]`;
  - operand `opd[0]` .. `opd[WIDTH-1]`.
- Opcodes and flag update at execute:
  - 00 LOAD: acc = opd; carry = 0.
  - 01 ADD: acc = (acc + opd) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 10 SUB: acc = (acc - opd) mod 2^WIDTH; carry = 1 iff acc < opd (borrow), unsigned compare on pre-execute values.
  - 11 XOR: acc = acc ^ opd; carry = 0.
- FSM states: IDLE, RX_OP, RX_DATA, EXEC, TX.
  - IDLE → RX_OP when `data` = 0 is sampled. `data` = 1 keeps IDLE.
  - RX_OP → RX_DATA after 2 opcode bits.
  - RX_DATA → EXEC after WIDTH operand bits; a bit counter of width clog2(WIDTH+1) tracks position.
  - EXEC → TX unconditionally; acc, carry and the TX shift register load on this edge.
  - TX → IDLE after WIDTH bits have been shifted out.
- `data` is ignored in RX_OP/RX_DATA except as payload, and fully ignored in EXEC and TX. A start bit arriving during EXEC/TX is lost, not queued.
- There is no error detection: any bit pattern after a start bit is accepted as payload.
- Reset values: state = IDLE, acc = 0, carry = 0, TX shift = 0, counter = 0. Outputs `write` = 0, `result` = 0, `busy` = 0.
- Reset asserted mid-frame or mid-TX aborts immediately (asynchronous). The accumulator is cleared, not preserved, and no partial frame survives.

## Timing
- `write` = (state == TX), `busy` = (state != IDLE), `result` = TX shift[0]. All are decoded from registers only; there is no combinational path from `data`.
- Let edge E0 sample the start bit in IDLE:
  - edges E1–E2 capture `op[0]`, `op[1]`;
  - edges E3..E(2+WIDTH) capture the operand;
  - edge E(3+WIDTH) is the execute edge.
- After E(3+WIDTH): `write` = 1, `result` = new acc[0], `carry` valid.
- Each following edge shifts one bit. acc[i] is presented in the cycle after edge E(3+WIDTH+i).
- Edge E(3+2·WIDTH) returns to IDLE; `write` falls. The earliest next start bit is sampled at edge E(4+2·WIDTH).
- Total frame occupancy: 3 + 2·WIDTH cycles. Back-to-back frames are allowed with `data` held low through the TX→IDLE edge.
- `busy` rises after E0 and falls after E(3+2·WIDTH).
- `carry` holds its value until the next execute edge or reset.

## Test plan
All scenarios use WIDTH = 8 unless stated.
- **Reset and idle:** rst low, then high with `data` held 1 for 20 cycles → `write`, `result`, `busy`, `carry` stay 0 throughout.
- **LOAD, then ADD:**
  - LOAD 0xA5 → 8 `write` cycles with `result` bits 1,0,1,0,0,1,0,1; `carry` = 0.
  - Then ADD 0x70 → serial 0x15; `carry` = 1.
- **SUB and XOR:**
  - From acc 0x15, SUB 0x20 → serial 0xF5; `carry` = 1.
  - Then XOR 0xFF → serial 0x0A; `carry` = 0.
- **Traffic ignored during TX:** toggle `data` every cycle during EXEC/TX of a LOAD 0x3C → output is exactly 0x3C, and the FSM returns to IDLE at E(19).
- **Abort on reset:** after LOAD 0x80, pulse rst low during operand bit 4 of an ADD 0x01, then send ADD 0x03 → serial 0x03; `write` never asserts for the aborted frame.
- **Narrow width, WIDTH = 4:**
  - LOAD 0xF, then ADD 0x1 → serial 0x0, `carry` = 1.
  - Frame spans 11 cycles.
  - Back-to-back second frame started at E(12) is accepted.
